multi_edge_detect: RTL and testbench
====================================

MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 Parameter FILTER_LEN, default 4: consecutive-cycle stability needed before a level change is accepted, 1..255.
REQ-004 Parameter CNT_W, default 8: width of the event counter, 4..32.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 sig  input  N  asynchronous level inputs, one per channel.
REQ-008 mode  input  2  global detect mode: 00 none, 01 rising, 10 falling, 11 both.
REQ-009 clr  input  N  per-channel sticky-flag clear, active-high, level-sampled.
REQ-010 cnt_clr  input  1  event-counter clear, active-high.
REQ-011 pe  output  N  registered one-cycle rising-edge pulse per channel.
REQ-012 ne  output  N  registered one-cycle falling-edge pulse per channel.
REQ-013 evt_sticky  output  N  per-channel latched event flag.
REQ-014 evt_any  output  1  OR of evt_sticky, combinational from evt_sticky.
REQ-015 evt_count  output  CNT_W  saturating count of accepted pulses.

Function
REQ-016 Each channel passes through a SYNC_STAGES-deep flop chain; sync_out is the last stage.
REQ-017 Each channel holds a filtered level "stable" and a filter counter fcnt (8 bits).
REQ-018 sync_out == stable: fcnt <= 0, stable unchanged.
REQ-019 sync_out != stable and fcnt < FILTER_LEN-1: fcnt <= fcnt+1.
REQ-020 sync_out != stable and fcnt == FILTER_LEN-1: stable <= sync_out, fcnt <= 0 (accepted change).
REQ-021 A glitch that reverts before FILTER_LEN consecutive differing cycles resets fcnt and produces no pulse.
REQ-022 On an accepted 0->1 change with mode[0]=1, pe[i] is 1 in the cycle stable first reads 1; otherwise pe[i]=0.
REQ-023 On an accepted 1->0 change with mode[1]=1, ne[i] is 1 in the cycle stable first reads 0; otherwise ne[i]=0.
REQ-024 Latency: input change set up before rising edge k gives pe/ne high after edge k+SYNC_STAGES+FILTER_LEN-1, for exactly one cycle.
REQ-025 mode is sampled in the cycle of the accepted change; mode changes never affect sync or filter state, and a masked change is not reported later.
REQ-026 pe[i] and ne[i] are never 1 in the same cycle.
REQ-027 evt_sticky[i] <= 1 when pe[i]|ne[i] is being asserted; else <= 0 when clr[i]=1; else holds. Set wins over simultaneous clr.
REQ-028 evt_count adds popcount(pe|ne) of the cycle being asserted (0..N); result saturates at 2^CNT_W-1, no wrap.
REQ-029 cnt_clr=1 in the same cycle as new pulses loads evt_count with that cycle's popcount (saturated); cnt_clr with no pulses loads 0.
REQ-030 Channels are fully independent; simultaneous events on all N channels are all reported and counted.

Reset
REQ-031 rst=0 at a rising edge clears sync flops, stable, fcnt, pe, ne, evt_sticky, evt_count to 0; evt_any reads 0.
REQ-032 Reset mid-filter discards partial counts; no pulse is generated by reset entry or by stable being forced to 0.
REQ-033 An input held high through reset release is treated as a 0->1 change: pe fires SYNC_STAGES+FILTER_LEN cycles after the first edge with rst=1 (mode[0]=1).

Verification
REQ-034 Defaults, mode=11, sig[0] 0->1 before edge 10 and held -> pe[0]=1 only after edge 15, evt_sticky[0]=1 from edge 15, evt_count=1.
REQ-035 Defaults, sig[1] high for 3 cycles then low -> no pe/ne on any channel, evt_count stays 0.
REQ-036 mode=01, sig[2] 0->1 then 1->0 with 10-cycle gaps -> one pe[2], no ne[2], evt_count=1; mode=10 repeat -> one ne[2] only.
REQ-037 N=4, all sig 0->1 together -> pe=4'b1111 in one cycle, evt_count +4; cnt_clr in that cycle -> evt_count=4.
REQ-038 CNT_W=4, 20 toggles on channel 0 -> evt_count=15 saturated; clr[0] in same cycle as a pulse -> evt_sticky[0] remains 1.
REQ-039 sig[3] high through reset, rst released before edge 1 -> pe[3] after edge 6; rst=0 mid-filter (fcnt=2) -> no pulse, all outputs 0.

Source files
------------

// File: rtl/multi_edge_detect.sv
// Multi-channel synchronised, glitch-filtered edge detector with per-channel
// sticky event flags and a saturating event counter.
module multi_edge_detect #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sig,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     clr,
    input  logic             cnt_clr,
    output logic [N-1:0]     pe,
    output logic [N-1:0]     ne,
    output logic [N-1:0]     evt_sticky,
    output logic             evt_any,
    output logic [CNT_W-1:0] evt_count
);

    localparam logic [7:0]          FiltLast = 8'(FILTER_LEN - 1);
    // Six extra bits hold a popcount of up to 32 without overflowing the sum.
    localparam int unsigned         SumW     = CNT_W + 6;
    localparam logic [SumW-1:0]     CntMax   = SumW'((64'd1 << CNT_W) - 64'd1);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     sync_out;
    logic [N-1:0]     stable_q, stable_d;
    logic [7:0]       fcnt_q [N];
    logic [7:0]       fcnt_d [N];
    logic [N-1:0]     accept;
    logic [N-1:0]     pe_q, pe_d;
    logic [N-1:0]     ne_q, ne_d;
    logic [N-1:0]     pulse_d;
    logic [N-1:0]     sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       pulse_cnt;
    logic [SumW-1:0]  count_sum;

    function automatic logic [5:0] popcount(input logic [N-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sig;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        accept   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if (sync_out[i] == stable_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] >= FiltLast) begin
                stable_d[i] = sync_out[i];
                fcnt_d[i]   = '0;
                accept[i]   = 1'b1;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    always_comb begin
        pe_d     = accept & stable_d & {N{mode[0]}};
        ne_d     = accept & ~stable_d & {N{mode[1]}};
        pulse_d  = pe_d | ne_d;
        sticky_d = pulse_d | (sticky_q & ~clr);
    end

    // Counter clear and new pulses in the same cycle: the pulses still count.
    always_comb begin
        pulse_cnt = popcount(pulse_d);
        count_sum = (cnt_clr ? '0 : SumW'(count_q)) + SumW'(pulse_cnt);
        if (count_sum > CntMax) begin
            count_d = '1;
        end else begin
            count_d = count_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stable_q <= '0;
            pe_q     <= '0;
            ne_q     <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            pe_q     <= pe_d;
            ne_q     <= ne_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            for (int unsigned i = 0; i < N; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    assign pe         = pe_q;
    assign ne         = ne_q;
    assign evt_sticky = sticky_q;
    assign evt_any    = |sticky_q;
    assign evt_count  = count_q;

    pe_ne_exclusive: assert property (@(posedge clk) !(|(pe_q & ne_q)));

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect: directed vector table, hand-written
// corner sequences, and randomised stimulus against a window-based reference model.
module tb_multi_edge_detect;

    localparam int N = 4;
    localparam int S = 2;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sig = '0;
    logic [1:0] mode = 2'b11;
    logic [3:0] clr = '0;
    logic       cnt_clr = 1'b0;

    logic [3:0] pe, ne, stk;
    logic       any;
    logic [7:0] cnt;
    logic [3:0] pe_s, ne_s, stk_s;
    logic       any_s;
    logic [3:0] cnt_s;

    int errors = 0;
    int checks = 0;

    multi_edge_detect #(.N(N), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .pe(pe), .ne(ne), .evt_sticky(stk), .evt_any(any), .evt_count(cnt)
    );

    multi_edge_detect #(.N(N), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
        .pe(pe_s), .ne(ne_s), .evt_sticky(stk_s), .evt_any(any_s), .evt_count(cnt_s)
    );

    always #5 clk = ~clk;

    // Reference model: delay line for the synchroniser, sliding window of filter inputs.
    logic [3:0] m_dl [$];
    logic [3:0] m_win [$];
    logic [3:0] m_stable = '0;
    logic [3:0] m_pe = '0;
    logic [3:0] m_ne = '0;
    logic [3:0] m_stk = '0;
    int         m_cnt = 0;
    int         m_cnt_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [3:0] fin, acc, nst;
        logic       diff;
        int         n;
        if (!rst) begin
            m_dl = {};
            for (int k = 0; k < S; k++) m_dl.push_back(4'b0000);
            m_win    = {};
            m_stable = '0;
            m_pe     = '0;
            m_ne     = '0;
            m_stk    = '0;
            m_cnt    = 0;
            m_cnt_s  = 0;
        end else begin
            fin = m_dl.pop_front();
            m_dl.push_back(sig);
            m_win.push_back(fin);
            if (m_win.size() > F) void'(m_win.pop_front());
            acc = '0;
            if (m_win.size() == F) begin
                for (int i = 0; i < N; i++) begin
                    diff = 1'b1;
                    for (int k = 0; k < F; k++) begin
                        if (m_win[k][i] == m_stable[i]) diff = 1'b0;
                    end
                    acc[i] = diff;
                end
            end
            nst      = m_stable ^ acc;
            m_pe     = acc & nst & {4{mode[0]}};
            m_ne     = acc & ~nst & {4{mode[1]}};
            m_stable = nst;
            m_stk    = (m_pe | m_ne) | (m_stk & ~clr);
            n        = $countones(m_pe | m_ne);
            m_cnt    = (cnt_clr ? 0 : m_cnt) + n;
            m_cnt_s  = (cnt_clr ? 0 : m_cnt_s) + n;
            if (m_cnt > 255) m_cnt = 255;
            if (m_cnt_s > 15) m_cnt_s = 15;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("mdl pe", 32'(pe), 32'(m_pe));
        chk("mdl ne", 32'(ne), 32'(m_ne));
        chk("mdl sticky", 32'(stk), 32'(m_stk));
        chk("mdl any", 32'(any), 32'(|m_stk));
        chk("mdl count", 32'(cnt), 32'(m_cnt));
        chk("mdl count_small", 32'(cnt_s), 32'(m_cnt_s));
        chk("mdl pe_small", 32'(pe_s | ne_s), 32'(m_pe | m_ne));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] sig;
        logic [1:0] mode;
        logic [3:0] clr;
        logic       cnt_clr;
        int         cyc;
        logic [3:0] epe;
        logic [3:0] ene;
        logic [3:0] estk;
        int         ecnt;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic [3:0] s, input logic [1:0] m,
                       input logic [3:0] c, input logic cc, input int cyc,
                       input logic [3:0] p, input logic [3:0] n, input logic [3:0] st,
                       input int ct);
        vec_t v;
        v.rst = r; v.sig = s; v.mode = m; v.clr = c; v.cnt_clr = cc; v.cyc = cyc;
        v.epe = p; v.ene = n; v.estk = st; v.ecnt = ct;
        tbl.push_back(v);
    endtask

    initial begin
        // rst  sig      mode   clr      cc    cyc pe       ne       sticky   cnt
        add(0, 4'b0000, 2'b11, 4'b0000, 0, 3,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 6,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 2'b11, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0001, 2'b11, 4'b0000, 0, 1,  4'b0001, 4'b0000, 4'b0001, 1);
        add(1, 4'b0001, 2'b11, 4'b0000, 0, 1,  4'b0000, 4'b0000, 4'b0001, 1);
        add(1, 4'b0011, 2'b11, 4'b0000, 0, 3,  4'b0000, 4'b0000, 4'b0001, 1);
        add(1, 4'b0001, 2'b11, 4'b0000, 0, 10, 4'b0000, 4'b0000, 4'b0001, 1);
        add(1, 4'b0001, 2'b11, 4'b1111, 1, 1,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 2'b01, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b0101, 2'b01, 4'b0000, 0, 1,  4'b0100, 4'b0000, 4'b0100, 1);
        add(1, 4'b0101, 2'b01, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0001, 2'b01, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0001, 2'b01, 4'b0000, 0, 1,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0001, 2'b01, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0101, 2'b10, 4'b0000, 0, 6,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0101, 2'b10, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0001, 2'b10, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0100, 1);
        add(1, 4'b0001, 2'b10, 4'b0000, 0, 1,  4'b0000, 4'b0100, 4'b0100, 2);
        add(1, 4'b0001, 2'b10, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b0100, 2);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0100, 2);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 1,  4'b0000, 4'b0001, 4'b0101, 3);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b0101, 3);
        add(1, 4'b0000, 2'b11, 4'b0100, 0, 1,  4'b0000, 4'b0000, 4'b0001, 3);
        add(1, 4'b0000, 2'b11, 4'b1111, 1, 1,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 2'b11, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 2'b11, 4'b0000, 0, 1,  4'b1111, 4'b0000, 4'b1111, 4);
        add(1, 4'b1111, 2'b11, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b1111, 4);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 5,  4'b0000, 4'b0000, 4'b1111, 4);
        add(1, 4'b0000, 2'b11, 4'b0000, 1, 1,  4'b0000, 4'b1111, 4'b1111, 4);
        add(1, 4'b0000, 2'b11, 4'b0000, 0, 4,  4'b0000, 4'b0000, 4'b1111, 4);

        foreach (tbl[r]) begin
            rst     = tbl[r].rst;
            sig     = tbl[r].sig;
            mode    = tbl[r].mode;
            clr     = tbl[r].clr;
            cnt_clr = tbl[r].cnt_clr;
            for (int c = 0; c < tbl[r].cyc; c++) step();
            chk($sformatf("vec%0d pe", r), 32'(pe), 32'(tbl[r].epe));
            chk($sformatf("vec%0d ne", r), 32'(ne), 32'(tbl[r].ene));
            chk($sformatf("vec%0d sticky", r), 32'(stk), 32'(tbl[r].estk));
            chk($sformatf("vec%0d any", r), 32'(any), 32'(|tbl[r].estk));
            chk($sformatf("vec%0d count", r), 32'(cnt), 32'(tbl[r].ecnt));
        end
        clr     = '0;
        cnt_clr = 1'b0;
        mode    = 2'b11;

        // Saturation on the narrow counter; clr coinciding with the last pulse.
        for (int t = 0; t < 20; t++) begin
            sig[0] = ~sig[0];
            for (int c = 0; c < 5; c++) step();
            if (t == 19) clr = 4'b0001;
            step();
            if (t == 19) begin
                chk("sat ne0", 32'(ne[0]), 32'd1);
                chk("sat sticky0 with clr", 32'(stk[0]), 32'd1);
            end
            clr = '0;
        end
        chk("sat count_small", 32'(cnt_s), 32'd15);
        chk("sat count_wide", 32'(cnt), 32'd24);

        // Input held high through reset release.
        sig = 4'b1000;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("rst pe", 32'(pe), 32'd0);
        chk("rst count", 32'(cnt), 32'd0);
        chk("rst any", 32'(any), 32'd0);
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("rel edge%0d pe", e), 32'(pe), (e == 6) ? 32'h8 : 32'h0);
        end

        // Reset asserted with a falling change partway through the filter.
        sig = 4'b0000;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b0;
        step();
        chk("midrst pe", 32'(pe), 32'd0);
        chk("midrst ne", 32'(ne), 32'd0);
        chk("midrst sticky", 32'(stk), 32'd0);
        chk("midrst count", 32'(cnt), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("postrst pulses", 32'(pe | ne), 32'd0);
        end

        // Randomised stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) sig[i] = ~sig[i];
                clr[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            cnt_clr = ($urandom_range(0, 99) == 0);
            rst     = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
